// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge
//
// Memory-side end of the instruction-cache refill path. It takes a cache miss
// request, performs one single-word read on the SRAM-like instruction bus, and
// returns the fetched word tagged with the PC it belongs to. While the miss is
// outstanding, the cache and CPU are held stalled.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   interface_enable       cache miss, fetch requested for interface_PC
//   interface_PC           PC to fetch
//   this_time_pc           PC that interface_instruction belongs to (registered)
//   interface_instruction  fetched word (registered)
//   cache_wait_stop_choke  stall to cache (combinational)
//   inst_req, inst_addr    bus read request and word-aligned address
//   inst_addr_ok           bus accepted the request this cycle
//   inst_data_ok           inst_rdata valid this cycle
//   inst_rdata             bus read data
//
// Build option:
//   IFETCH_DISCARD_EN  When defined, a PC redirect seen while waiting for data
//                      drops the returned word and skips DONE.

module inst_fetch_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        interface_enable,
  input  logic [31:0] interface_PC,
  output logic [31:0] this_time_pc,
  output logic [31:0] interface_instruction,
  output logic        cache_wait_stop_choke,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q;
  logic [31:0] this_time_pc_q;
  logic [31:0] inst_word_q;
  logic        capture;

`ifdef IFETCH_DISCARD_EN
  logic discard_q, discard_d;
  logic drop;

  // A redirect in the same cycle as data_ok also drops the word.
  assign drop = discard_q | (interface_PC != fetch_pc_q);

  always_comb begin
    discard_d = discard_q;
    if (state_q == StWait) begin
      if (inst_data_ok) begin
        discard_d = 1'b0;
      end else if (interface_PC != fetch_pc_q) begin
        discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      discard_q <= 1'b0;
    end else begin
      discard_q <= discard_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (interface_enable) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (inst_addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
`ifdef IFETCH_DISCARD_EN
          if (drop) begin
            state_d = StIdle;
          end else begin
            state_d = StDone;
            capture = 1'b1;
          end
`else
          state_d = StDone;
          capture = 1'b1;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      fetch_pc_q     <= '0;
      this_time_pc_q <= '0;
      inst_word_q    <= '0;
    end else begin
      state_q <= state_d;
      // PC is latched only on leaving IDLE so the bus address stays stable.
      if (state_q == StIdle && interface_enable) begin
        fetch_pc_q <= interface_PC;
      end
      if (capture) begin
        this_time_pc_q <= fetch_pc_q;
        inst_word_q    <= inst_rdata;
      end
    end
  end

  assign inst_req              = (state_q == StReq);
  assign inst_addr             = inst_req ? {fetch_pc_q[31:2], 2'b00} : 32'h0;
  assign this_time_pc          = this_time_pc_q;
  assign interface_instruction = inst_word_q;

  // Stall drops only in DONE and only if the delivered word is for the PC the
  // cache is asking about now; a stale word after a redirect keeps it high.
  assign cache_wait_stop_choke = interface_enable &
                                 ~((state_q == StDone) && (this_time_pc_q == interface_PC));

endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Memory-side end of the instruction-cache refill path. It accepts the cache's miss request, performs a single-word read on the SRAM-like instruction bus, and returns the fetched word together with the PC it belongs to, so the cache can fill its tag and data arrays. While the miss is outstanding it holds the cache and CPU stalled. The block sits between the instruction cache and the top-level instruction bus port.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- interface_enable  in  1  cache miss: fetch requested for interface_PC
- interface_PC  in  32  PC to fetch
- this_time_pc  out  32  PC that interface_instruction belongs to (registered)
- interface_instruction  out  32  fetched word (registered)
- cache_wait_stop_choke  out  1  stall to cache; high while the requested word is not yet delivered
- inst_req  out  1  bus read request
- inst_addr  out  32  bus address, word aligned
- inst_addr_ok  in  1  bus accepted request/address this cycle
- inst_data_ok  in  1  inst_rdata valid this cycle
- inst_rdata  in  32  bus read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - interface_enable=1: latch fetch_pc<=interface_PC and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - inst_req=1, inst_addr={fetch_pc[31:2],2'b00}.
  - Address and request stay stable until inst_addr_ok; they do not track interface_PC changes.
  - inst_addr_ok=1: go to WAIT.
- WAIT:
  - inst_req=0.
  - inst_data_ok=1: interface_instruction<=inst_rdata, this_time_pc<=fetch_pc, go to DONE.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE.
  - In DONE the cache writes its arrays. On the next cycle it hits and drops interface_enable.
- Stall: cache_wait_stop_choke = interface_enable & ~(state==DONE & this_time_pc==interface_PC). The stall is combinational.
- PC changed by DONE (mismatch): stall stays high. IDLE then re-latches the new PC. The stale word is still presented for that one cycle; the cache ignores it because the stall is high.
- At most one bus transaction is outstanding. A new inst_req is never issued before the previous inst_data_ok.
- this_time_pc and interface_instruction hold their values outside DONE. The cache may rewrite the same entry with identical contents while idle; this is harmless.
- Reset outputs: inst_req=0, inst_addr=0, this_time_pc=0, interface_instruction=0, cache_wait_stop_choke=interface_enable.
- Reset mid-operation returns to IDLE. The bus slave shares this reset, so no stray inst_data_ok is tracked.

## Timing
- inst_req is a registered state decode and goes high the cycle after the miss is seen.
- Minimum miss latency, with addr_ok and data_ok each at first opportunity:
  - cycle 0: IDLE with enable, stall=1
  - cycle 1: REQ, inst_addr_ok=1
  - cycle 2: WAIT, inst_data_ok=1
  - cycle 3: DONE, stall=0, word valid
- Each addr_ok wait cycle and each data_ok delay cycle adds one cycle.
- inst_addr_ok in the same cycle the FSM enters REQ is honoured.
- inst_data_ok is ignored outside WAIT.

## Configuration
- IFETCH_DISCARD_EN defined:
  - In WAIT, interface_PC != fetch_pc sets a discard flag.
  - The returned word is then dropped: DONE is skipped and outputs are not updated.
  - The FSM goes directly to IDLE, saving one cycle on redirects.
  - The flag clears on inst_data_ok or reset.
- Undefined: no flag. A redirect is resolved by the DONE mismatch rule above.

## Test plan
- Reset, enable=0: inst_req=0, this_time_pc=0, stall=0. Then enable=1 with PC=0x1FC00000: stall=1 immediately.
- Single miss, PC=0xBFC00004, addr_ok in cycle 1, data_ok in cycle 2 with rdata=0x24080001: inst_addr=0xBFC00004 in cycle 1; DONE in cycle 3 with interface_instruction=0x24080001, this_time_pc=0xBFC00004, stall=0.
- Slave inserts 3 addr_ok waits and 2 data_ok waits: inst_req/inst_addr stay stable throughout; DONE occurs at cycle 8.
- PC changes from 0x100 to 0x200 during WAIT:
  - Macro off: DONE shows 0x100 with stall=1, then a second request to 0x200.
  - Macro on: no DONE for 0x100, inst_req for 0x200 one cycle earlier.
- Reset asserted in WAIT: next cycle IDLE, inst_req=0, outputs cleared. A following miss completes normally.
- Back-to-back misses 0x0, 0x4, 0x8 with enable held: exactly one inst_req per PC, and never two outstanding transactions.
